// File: rtl/mac_lookup_arbiter_pkg.sv
// Shared definitions for the MAC table read-side (DA lookup) arbiter:
// default sizing, FSM state encoding and modulo helper for round-robin search.
package mac_lookup_arbiter_pkg;

    localparam int PORT_NUM_DEF = 4;
    localparam int MAC_W_DEF    = 48;
    localparam int TIMEOUT_DEF  = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // (a + b) mod n for 0 <= a,b < n; avoids relying on power-of-two wrap.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/mac_lookup_arbiter_rr_pick.sv
// MAC_rr_pick: combinational rotating-priority picker. The pointer names the
// highest-priority port; the search proceeds ptr, ptr+1, ... modulo pPORT_NUM,
// so it stays in range for non-power-of-two port counts.
module MAC_rr_pick
    import mac_lookup_arbiter_pkg::*;
#(
    parameter  int pPORT_NUM = PORT_NUM_DEF,
    localparam int IW        = $clog2(pPORT_NUM)
) (
    input  logic [pPORT_NUM-1:0] i_req,
    input  logic [IW-1:0]        i_ptr,
    output logic                 o_any,
    output logic [IW-1:0]        o_win
);

    logic [IW-1:0] cand;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        o_any = 1'b0;
        o_win = '0;
        cand  = '0;
        for (int i = pPORT_NUM - 1; i >= 0; i--) begin
            cand = IW'(wrap_add(int'(i_ptr), i, pPORT_NUM));
            if (i_req[cand]) begin
                o_any = 1'b1;
                o_win = cand;
            end
        end
    end

endmodule

// File: rtl/mac_lookup_arbiter.sv
// mac_lookup_arbiter: grants per-port DA lookup requests one at a time in
// round-robin order, issues a single MAC table read, waits for the answer or a
// timeout and returns hit/egress port to the requesting port only.
// Every output is a flop; next-state logic computes the output values for the
// state being entered.
module mac_lookup_arbiter
    import mac_lookup_arbiter_pkg::*;
#(
    parameter  int pPORT_NUM = PORT_NUM_DEF,
    parameter  int pMAC_W    = MAC_W_DEF,
    parameter  int pTIMEOUT  = TIMEOUT_DEF,
    localparam int IW        = $clog2(pPORT_NUM),
    localparam int CW        = $clog2(pTIMEOUT + 1)
) (
    input  logic                        iclk,
    input  logic                        irst,
    input  logic [pPORT_NUM-1:0]        i_lookup_req,
    input  logic [pPORT_NUM*pMAC_W-1:0] i_DA,
    output logic [pPORT_NUM-1:0]        o_lookup_ack,
    output logic                        o_rd_en,
    output logic [pMAC_W-1:0]           o_rd_DA,
    input  logic                        i_rd_valid,
    input  logic                        i_rd_hit,
    input  logic [IW-1:0]               i_rd_port,
    output logic [pPORT_NUM-1:0]        o_resp_valid,
    output logic                        o_resp_hit,
    output logic [IW-1:0]               o_resp_port,
    output logic                        o_timeout
);

    state_e                 state_q, state_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]          win_q, win_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [pMAC_W-1:0]      rd_da_q, rd_da_d;
    logic [pPORT_NUM-1:0]   ack_q, ack_d;
    logic                   rd_en_q, rd_en_d;
    logic [pPORT_NUM-1:0]   resp_valid_q, resp_valid_d;
    logic                   resp_hit_q, resp_hit_d;
    logic [IW-1:0]          resp_port_q, resp_port_d;
    logic                   timeout_q, timeout_d;

    logic                   pick_any;
    logic [IW-1:0]          pick_win;

    MAC_rr_pick #(
        .pPORT_NUM (pPORT_NUM)
    ) u_rr_pick (
        .i_req (i_lookup_req),
        .i_ptr (rr_ptr_q),
        .o_any (pick_any),
        .o_win (pick_win)
    );

    // Next-state and registered-output values; pulses default low each cycle.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        win_d        = win_q;
        cnt_d        = cnt_q;
        rd_da_d      = rd_da_q;
        ack_d        = '0;
        rd_en_d      = 1'b0;
        resp_valid_d = '0;
        resp_hit_d   = 1'b0;
        resp_port_d  = '0;
        timeout_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    win_d           = pick_win;
                    rd_da_d         = i_DA[int'(pick_win)*pMAC_W +: pMAC_W];
                    rr_ptr_d        = IW'(wrap_add(int'(pick_win), 1, pPORT_NUM));
                    ack_d[pick_win] = 1'b1;
                    rd_en_d         = 1'b1;
                    state_d         = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A table answer in the expiry cycle takes precedence.
                if (i_rd_valid) begin
                    resp_valid_d[win_q] = 1'b1;
                    resp_hit_d          = i_rd_hit;
                    resp_port_d         = i_rd_hit ? i_rd_port : '0;
                    state_d             = ST_RESP;
                end else if (cnt_q == CW'(pTIMEOUT - 1)) begin
                    resp_valid_d[win_q] = 1'b1;
                    timeout_d           = 1'b1;
                    state_d             = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, capture and output registers with synchronous reset.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            win_q        <= '0;
            cnt_q        <= '0;
            rd_da_q      <= '0;
            ack_q        <= '0;
            rd_en_q      <= 1'b0;
            resp_valid_q <= '0;
            resp_hit_q   <= 1'b0;
            resp_port_q  <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            rd_da_q      <= rd_da_d;
            ack_q        <= ack_d;
            rd_en_q      <= rd_en_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_port_q  <= resp_port_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_lookup_ack = ack_q;
    assign o_rd_en      = rd_en_q;
    assign o_rd_DA      = rd_da_q;
    assign o_resp_valid = resp_valid_q;
    assign o_resp_hit   = resp_hit_q;
    assign o_resp_port  = resp_port_q;
    assign o_timeout    = timeout_q;

endmodule

// File: doc/mac_lookup_arbiter.md
# mac_lookup_arbiter

Read-side companion of the MAC table's learning arbiter. Ports raise destination-address (DA) lookup requests. The block grants them one at a time in round-robin order and issues a single read to the MAC table. It waits for the table's answer, or a timeout, and returns the hit/miss and egress port to the requesting port only. It sits between the per-port ingress logic and the MAC table read port. Only one lookup is outstanding at a time.

## Interface
- pPORT_NUM, 4, number of switch ports
- pMAC_W, 48, MAC address width
- pTIMEOUT, 15, max cycles waited in WAIT for i_rd_valid before forced miss
- iclk  input  1  clock, all logic on posedge
- irst  input  1  synchronous, active-high reset
- i_lookup_req  input  pPORT_NUM  per-port level request; held until o_lookup_ack
- i_DA  input  pPORT_NUM*pMAC_W  per-port DA; port k at bits [k*pMAC_W +: pMAC_W]; valid while request held
- o_lookup_ack  output  pPORT_NUM  one-hot, one-cycle pulse: request accepted
- o_rd_en  output  1  one-cycle table read strobe
- o_rd_DA  output  pMAC_W  DA being looked up, held from ISSUE until return to IDLE
- i_rd_valid  input  1  table answer valid (one cycle)
- i_rd_hit  input  1  DA found
- i_rd_port  input  $clog2(pPORT_NUM)  egress port on hit
- o_resp_valid  output  pPORT_NUM  one-hot, one-cycle pulse to the requester
- o_resp_hit  output  1  qualifies o_resp_valid
- o_resp_port  output  $clog2(pPORT_NUM)  egress port; 0 on miss
- o_timeout  output  1  one-cycle pulse when a lookup is closed by timeout

## Operation
- FSM states:
  - IDLE: if any i_lookup_req bit is set, pick a winner round-robin, capture its DA and index, then go to ISSUE.
  - ISSUE: o_rd_en=1 and o_lookup_ack[winner]=1 for this one cycle. Clear the timeout counter. Go to WAIT.
  - WAIT: on i_rd_valid, capture hit/port and go to RESP. Otherwise increment the counter. When the counter reaches pTIMEOUT-1 without valid, force a miss, pulse o_timeout, and go to RESP.
  - RESP: o_resp_valid[winner]=1 with o_resp_hit/o_resp_port. Go to IDLE.
- Round-robin:
  - r_rr_ptr holds the highest-priority port for the next search.
  - The search order is r_rr_ptr, r_rr_ptr+1, …, wrapping modulo pPORT_NUM. This must be correct for non-power-of-two pPORT_NUM.
  - After a grant, r_rr_ptr = (winner+1) mod pPORT_NUM.
- i_rd_valid outside WAIT is ignored.
- If i_rd_valid arrives in the same cycle the timeout expires, valid wins: the table answer is used and there is no o_timeout pulse.
- A miss sets o_resp_hit=0 and o_resp_port=0. The ingress logic floods.
- A request dropped before ack is simply not granted; no error.
- i_DA is sampled only in the IDLE grant cycle. Later changes do not affect o_rd_DA.

## Timing
- Reset values: state IDLE, r_rr_ptr=0, counter=0. All outputs 0, including o_rd_DA.
- Reset mid-lookup abandons the lookup with no response. A late i_rd_valid is then ignored because the FSM is in IDLE.
- The request is seen in IDLE at cycle T:
  - ack and o_rd_en at T+1.
  - With table latency L (i_rd_valid at T+1+L, L≥1), o_resp_valid at T+2+L.
  - Timeout case: o_resp_valid and o_timeout together at T+2+pTIMEOUT.
- The FSM returns to IDLE the cycle after RESP. The minimum grant-to-grant spacing is L+3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- header.v holds:
  - pPORT_NUM, pMAC_W, pTIMEOUT defaults
  - FSM state localparams: IDLE, ISSUE, WAIT, RESP
- One sub-module, MAC_rr_pick: combinational rotating-priority picker.
  - Inputs: request vector, pointer.
  - Outputs: any-request flag, winner index.
  - It is reused by the learning-side arbiter if that block moves from polling to true round-robin.
- Everything else (FSM, counter, capture registers) lives in mac_lookup_arbiter.

## Test plan
- Single request, hit:
  - Stimulus: port 2 requests DA 0x0011_2233_4455; the table model answers after L=2 with hit=1, port=3.
  - Required response: ack[2] and o_rd_en at T+1, o_rd_DA=0x001122334455, o_resp_valid=4'b0100, hit=1, port=3 at T+4.
- All four ports request simultaneously from reset:
  - Required response: grant order 0,1,2,3; after that, with port 0 re-requesting and port 3 held, the next grant order is 0 then 3.
- Timeout:
  - Stimulus: port 1 requests and the table never answers.
  - Required response: o_timeout and o_resp_valid=4'b0010 with hit=0, port=0 exactly 17 cycles after the request (pTIMEOUT=15).
- Valid coincides with timeout expiry:
  - Required response: the response carries the table's hit and port, and o_timeout stays 0.
- Reset mid-lookup:
  - Stimulus: assert irst in WAIT, then the table answers 1 cycle after reset deasserts.
  - Required response: no o_resp_valid, all outputs 0, and the next request is served normally starting from pointer 0.
- pPORT_NUM=3 build:
  - Stimulus: ports 2 and 0 request back-to-back.
  - Required response: pointer wraps 2→0, grant order 2 then 0, no out-of-range index.
